vga_timing_gen: RTL and testbench

//  Source end of the pixel-coordinate interface: produces VGA_horzCoord/VGA_vertCoord plus

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/vga_axis_counter.sv | 52 +++++
 rtl/vga_timing_gen.sv | 94 +++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants for 1280x1024@60 (108 MHz pixel clock), shared by the
// timing generator and by any renderer that needs the sync windows.
package vga_timing_pkg;

  localparam int COORD_W = 12;
  typedef logic [COORD_W-1:0] coord_t;

  localparam int H_VIS   = 1280;
  localparam int H_FP    = 48;
  localparam int H_SYNC  = 112;
  localparam int H_BP    = 248;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 1024;
  localparam int V_FP    = 1;
  localparam int V_SYNC  = 3;
  localparam int V_BP    = 38;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic HS_POL = 1'b1;
  localparam logic VS_POL = 1'b1;

  // Inclusive sync windows in counter coordinates
  localparam int H_SYNC_START = H_VIS + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_VIS + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  function automatic bit in_window(input int pos, input int lo, input int hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One display axis: wrapping position counter with registered sync and
// visible flags derived from the next count, so they line up with count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int   VIS  = 1280,
  parameter int   FP   = 48,
  parameter int   SYNC = 112,
  parameter int   BP   = 248,
  parameter logic POL  = 1'b1
) (
  input  logic   CLK,
  input  logic   RESETN,
  input  logic   advance,
  output coord_t count,
  output logic   wrap,
  output logic   sync,
  output logic   vis
);

  localparam int     TOTAL      = VIS + FP + SYNC + BP;
  localparam int     SYNC_START = VIS + FP;
  localparam int     SYNC_END   = SYNC_START + SYNC - 1;
  localparam coord_t LAST       = coord_t'(TOTAL - 1);

  if (TOTAL > 4096) begin : g_total_chk
    $error("vga_axis_counter: axis total %0d exceeds 4096", TOTAL);
  end
  if (VIS < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_min_chk
    $error("vga_axis_counter: visible, porch and sync widths must all be >= 1");
  end

  coord_t count_nxt;

  // wrap is combinational: it gates the next axis on the same edge
  assign wrap      = (count == LAST);
  assign count_nxt = wrap ? '0 : count + coord_t'(1);

  // Position and flags advance together, held when advance is low
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count <= LAST;
      sync  <= ~POL;
      vis   <= 1'b0;
    end else if (advance) begin
      count <= count_nxt;
      sync  <= in_window(int'(count_nxt), SYNC_START, SYNC_END) ? POL : ~POL;
      vis   <= (int'(count_nxt) < VIS);
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Display timing master: horizontal and vertical axis counters plus
// registered active/line/frame flags aligned to the shown coordinates.
module vga_timing_gen #(
  parameter int   H_VIS  = vga_timing_pkg::H_VIS,
  parameter int   H_FP   = vga_timing_pkg::H_FP,
  parameter int   H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int   H_BP   = vga_timing_pkg::H_BP,
  parameter int   V_VIS  = vga_timing_pkg::V_VIS,
  parameter int   V_FP   = vga_timing_pkg::V_FP,
  parameter int   V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int   V_BP   = vga_timing_pkg::V_BP,
  parameter logic HS_POL = vga_timing_pkg::HS_POL,
  parameter logic VS_POL = vga_timing_pkg::VS_POL
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        CE,
  output logic [11:0] VGA_horzCoord,
  output logic [11:0] VGA_vertCoord,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_active,
  output logic        line_start,
  output logic        frame_start
);

  import vga_timing_pkg::*;

  coord_t h_count, v_count;
  logic   h_wrap, v_wrap;
  logic   h_sync, v_sync;
  logic   h_vis, v_vis;
  logic   h_vis_nxt, v_vis_nxt;

  vga_axis_counter #(
    .VIS (H_VIS),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .POL (HS_POL)
  ) u_horz (
    .CLK    (CLK),
    .RESETN (RESETN),
    .advance(CE),
    .count  (h_count),
    .wrap   (h_wrap),
    .sync   (h_sync),
    .vis    (h_vis)
  );

  vga_axis_counter #(
    .VIS (V_VIS),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .POL (VS_POL)
  ) u_vert (
    .CLK    (CLK),
    .RESETN (RESETN),
    .advance(CE & h_wrap),
    .count  (v_count),
    .wrap   (v_wrap),
    .sync   (v_sync),
    .vis    (v_vis)
  );

  assign VGA_horzCoord = h_count;
  assign VGA_vertCoord = v_count;
  assign VGA_HS        = h_sync;
  assign VGA_VS        = v_sync;

  // Next-cycle visibility of each axis, from current flag and position
  always_comb begin
    h_vis_nxt = h_wrap | (h_vis & (h_count != coord_t'(H_VIS - 1)));
    v_vis_nxt = v_vis;
    if (h_wrap) begin
      v_vis_nxt = v_wrap | (v_vis & (v_count != coord_t'(V_VIS - 1)));
    end
  end

  // Flags registered from next-state values so they match the coords shown
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      VGA_active  <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (CE) begin
      VGA_active  <= h_vis_nxt & v_vis_nxt;
      line_start  <= h_wrap;
      frame_start <= h_wrap & v_wrap;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line-level behaviour and a
// reduced-geometry instance for whole-frame, vertical sync and CE gating.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam int S_HVIS = 8, S_HFP = 2, S_HSYNC = 3, S_HBP = 2;
  localparam int S_VVIS = 4, S_VFP = 1, S_VSYNC = 2, S_VBP = 1;
  localparam int S_HTOT = S_HVIS + S_HFP + S_HSYNC + S_HBP;  // 15
  localparam int S_VTOT = S_VVIS + S_VFP + S_VSYNC + S_VBP;  // 8

  typedef struct packed {
    logic [11:0] h;
    logic [11:0] v;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
  } obs_t;

  logic clk = 1'b0;
  logic rstn_a = 1'b0, ce_a = 1'b0;
  logic rstn_b = 1'b0, ce_b = 1'b0;
  logic [11:0] h_a, v_a, h_b, v_b;
  logic hs_a, vs_a, act_a, ls_a, fs_a;
  logic hs_b, vs_b, act_b, ls_b, fs_b;

  always #5 clk = ~clk;

  vga_timing_gen dut (
    .CLK(clk), .RESETN(rstn_a), .CE(ce_a),
    .VGA_horzCoord(h_a), .VGA_vertCoord(v_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a), .VGA_active(act_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_VIS(S_HVIS), .H_FP(S_HFP), .H_SYNC(S_HSYNC), .H_BP(S_HBP),
    .V_VIS(S_VVIS), .V_FP(S_VFP), .V_SYNC(S_VSYNC), .V_BP(S_VBP),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_s (
    .CLK(clk), .RESETN(rstn_b), .CE(ce_b),
    .VGA_horzCoord(h_b), .VGA_vertCoord(v_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b), .VGA_active(act_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int   sel = 0;
  int   p_hvis, p_hfp, p_hsync, p_htot, p_vvis, p_vfp, p_vsync, p_vtot;
  int   mh, mv;
  bit   m_rst;
  obs_t m_exp;
  obs_t sb[$];

  function automatic obs_t expect_at(input int h, input int v);
    obs_t o;
    o.h   = 12'(h);
    o.v   = 12'(v);
    o.hs  = (h >= p_hvis + p_hfp) && (h < p_hvis + p_hfp + p_hsync);
    o.vs  = (v >= p_vvis + p_vfp) && (v < p_vvis + p_vfp + p_vsync);
    o.act = (h < p_hvis) && (v < p_vvis);
    o.ls  = (h == 0);
    o.fs  = (h == 0) && (v == 0);
    return o;
  endfunction

  task automatic model_reset();
    m_rst   = 1'b1;
    mh      = p_htot - 1;
    mv      = p_vtot - 1;
    m_exp   = '0;
    m_exp.h = 12'(mh);
    m_exp.v = 12'(mv);
  endtask

  task automatic model_adv();
    if (mh == p_htot - 1) begin
      mh = 0;
      mv = (mv == p_vtot - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    m_exp = expect_at(mh, mv);
  endtask

  function automatic obs_t sample();
    obs_t o;
    if (sel == 0) o = '{h_a, v_a, hs_a, vs_a, act_a, ls_a, fs_a};
    else          o = '{h_b, v_b, hs_b, vs_b, act_b, ls_b, fs_b};
    return o;
  endfunction

  task automatic compare(input string tag, input obs_t got, input obs_t exp);
    check({tag, "_h"},   32'(got.h),   32'(exp.h));
    check({tag, "_v"},   32'(got.v),   32'(exp.v));
    check({tag, "_hs"},  32'(got.hs),  32'(exp.hs));
    check({tag, "_vs"},  32'(got.vs),  32'(exp.vs));
    check({tag, "_act"}, 32'(got.act), 32'(exp.act));
    check({tag, "_ls"},  32'(got.ls),  32'(exp.ls));
    check({tag, "_fs"},  32'(got.fs),  32'(exp.fs));
  endtask

  // Drive CE on the falling edge, push the expectation, compare after the rising edge
  task automatic step(input bit ce_v);
    @(negedge clk);
    if (sel == 0) ce_a = ce_v;
    else          ce_b = ce_v;
    if (ce_v && !m_rst) model_adv();
    sb.push_back(m_exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) check("sb_empty", 0, 1);
    else                compare("step", sample(), sb.pop_front());
  endtask

  task automatic walk_to(input int h, input int v, input int budget);
    int n = 0;
    while (!(mh == h && mv == v) && n < budget) begin
      step(1'b1);
      n++;
    end
    check("walk_h", (sel == 0) ? 32'(h_a) : 32'(h_b), h);
    check("walk_v", (sel == 0) ? 32'(v_a) : 32'(v_b), v);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int ce_cnt = 0;
    int prev = -1;
    int nfr = 0;

    // ---------------- full-size instance ----------------
    sel = 0;
    p_hvis = H_VIS; p_hfp = H_FP; p_hsync = H_SYNC; p_htot = H_TOTAL;
    p_vvis = V_VIS; p_vfp = V_FP; p_vsync = V_SYNC; p_vtot = V_TOTAL;
    model_reset();
    step(1'b0);
    step(1'b1);
    check("rst_h", h_a, 1687);
    check("rst_v", v_a, 1065);
    check("rst_hs", hs_a, 0);
    check("rst_fs", fs_a, 0);
    ce_a = 1'b0;
    rstn_a = 1'b1;
    m_rst = 1'b0;

    step(1'b1);
    check("first_h", h_a, 0);
    check("first_v", v_a, 0);
    check("first_act", act_a, 1);
    check("first_ls", ls_a, 1);
    check("first_fs", fs_a, 1);
    step(1'b1);
    check("second_h", h_a, 1);
    check("second_ls", ls_a, 0);
    check("second_fs", fs_a, 0);
    repeat (3) step(1'b0);
    check("hold_h", h_a, 1);

    walk_to(1279, 0, 2000);
    check("act_1279", act_a, 1);
    step(1'b1);
    check("act_1280", act_a, 0);
    walk_to(1327, 0, 2000);
    check("hs_1327", hs_a, 0);
    step(1'b1);
    check("hs_1328", hs_a, 1);
    walk_to(1439, 0, 2000);
    check("hs_1439", hs_a, 1);
    step(1'b1);
    check("hs_1440", hs_a, 0);

    walk_to(1687, 5, 12000);
    step(1'b1);
    check("wrap6_h", h_a, 0);
    check("wrap6_v", v_a, 6);
    check("wrap6_ls", ls_a, 1);
    check("wrap6_fs", fs_a, 0);

    walk_to(700, 6, 2000);
    @(negedge clk);
    rstn_a = 1'b0;
    model_reset();
    #1;
    compare("async_rst", sample(), m_exp);
    check("async_rst_h", h_a, 1687);
    check("async_rst_v", v_a, 1065);
    step(1'b1);
    step(1'b0);
    rstn_a = 1'b1;
    m_rst = 1'b0;
    step(1'b1);
    check("restart_h", h_a, 0);
    check("restart_v", v_a, 0);
    check("restart_fs", fs_a, 1);
    step(1'b1);

    // ---------------- reduced-geometry instance ----------------
    sel = 1;
    p_hvis = S_HVIS; p_hfp = S_HFP; p_hsync = S_HSYNC; p_htot = S_HTOT;
    p_vvis = S_VVIS; p_vfp = S_VFP; p_vsync = S_VSYNC; p_vtot = S_VTOT;
    model_reset();
    step(1'b0);
    rstn_b = 1'b1;
    m_rst = 1'b0;

    for (int i = 0; i < 700 && nfr < 3; i++) begin
      bit c;
      c = (i % 2 == 0) && !(i >= 40 && i < 50);
      step(c);
      if (c) begin
        ce_cnt++;
        if (mv == 4) check("vs_line4", vs_b, 0);
        if (mv == 5 || mv == 6) check("vs_sync_line", vs_b, 1);
        if (mv == 7) check("vs_line7", vs_b, 0);
        if (fs_b) begin
          if (prev >= 0) check("frame_period", ce_cnt - prev, S_HTOT * S_VTOT);
          prev = ce_cnt;
          nfr++;
        end
      end
    end
    check("frame_count", nfr, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
